// File: rtl/datapath_mc.sv
// Multi-cycle RV32-style datapath: one instruction per valid/ready handshake, stepped
// through DECODE/EXEC/[MEM]/WB with an internal register file, ALU and wait-stated data memory.
module datapath_mc #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int DMEM_DEPTH = 256,
  parameter int MEM_LAT    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [31:0]     inst,
  input  logic [2:0]      ImmSel,
  input  logic            RegWEn,
  input  logic            Bsel,
  input  logic [3:0]      ALUSel,
  input  logic            MemRW,
  input  logic            WBSel,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(XLEN);
  localparam int AW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

  state_t state, state_next;

  logic [31:7]     inst_q;
  logic [2:0]      imm_sel_q;
  logic            reg_wen_q, bsel_q, mem_rw_q, wb_sel_q;
  logic [3:0]      alu_sel_q;
  logic [XLEN-1:0] a_q, b_q, imm_q, alu_q;
  logic [3:0]      wait_cnt;
  logic            mem_last;

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];

  logic [RW-1:0]   rs1, rs2, rd;
  logic [31:0]     imm_raw;
  logic [XLEN-1:0] imm_ext, op_b, alu_res, wb_value, rd_word;
  logic [SW-1:0]   shamt;
  logic [AW-1:0]   mem_idx;

  // Opcode bits carry no information here: control arrives on its own ports.
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];

  assign rs1        = inst_q[15 +: RW];
  assign rs2        = inst_q[20 +: RW];
  assign rd         = inst_q[7 +: RW];
  assign mem_last   = (wait_cnt == 4'(MEM_LAT));
  assign mem_idx    = alu_q[AW+1:2];
  assign rd_word    = dmem[mem_idx];
  assign inst_ready = (state == IDLE);
  assign dbg_data   = regs[dbg_addr[RW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (inst_valid) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = (mem_rw_q || !wb_sel_q) ? MEM : WB;
      MEM:     if (mem_last) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imm_raw = '0;
    case (imm_sel_q)
      3'b000:  imm_raw = {{20{inst_q[31]}}, inst_q[31:20]};
      3'b001:  imm_raw = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      3'b010:  imm_raw = {inst_q[31:12], 12'b0};
      3'b011:  imm_raw = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
      3'b100:  imm_raw = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
      default: imm_raw = '0;
    endcase
  end
  assign imm_ext = XLEN'($signed(imm_raw));

  assign op_b  = bsel_q ? imm_q : b_q;
  assign shamt = op_b[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_sel_q)
      4'd0:    alu_res = a_q + op_b;
      4'd1:    alu_res = a_q - op_b;
      4'd2:    alu_res = a_q << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(op_b)};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, a_q < op_b};
      4'd5:    alu_res = a_q ^ op_b;
      4'd6:    alu_res = a_q >> shamt;
      4'd7:    alu_res = $signed(a_q) >>> shamt;
      4'd8:    alu_res = a_q | op_b;
      4'd9:    alu_res = a_q & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // The ALU-only path enters WB straight from EXEC, before alu_q is loaded.
  assign wb_value = !wb_sel_q ? rd_word : ((state == EXEC) ? alu_res : alu_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q    <= '0;
      imm_sel_q <= '0;
      reg_wen_q <= 1'b0;
      bsel_q    <= 1'b0;
      alu_sel_q <= '0;
      mem_rw_q  <= 1'b0;
      wb_sel_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      wait_cnt  <= '0;
    end else begin
      if (state == IDLE && inst_valid) begin
        inst_q    <= inst[31:7];
        imm_sel_q <= ImmSel;
        reg_wen_q <= RegWEn;
        bsel_q    <= Bsel;
        alu_sel_q <= ALUSel;
        mem_rw_q  <= MemRW;
        wb_sel_q  <= WBSel;
      end
      if (state == DECODE) begin
        a_q   <= regs[rs1];
        b_q   <= regs[rs2];
        imm_q <= imm_ext;
      end
      if (state == EXEC) alu_q <= alu_res;
      wait_cnt <= (state == MEM && !mem_last) ? wait_cnt + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (state_next == WB) begin
      done    <= 1'b1;
      wb_en   <= reg_wen_q && (rd != '0);
      wb_addr <= 5'(rd);
      wb_data <= wb_value;
    end else begin
      done  <= 1'b0;
      wb_en <= 1'b0;
    end
  end

  // Register 0 is never written, so it reads as zero without a special case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == WB && wb_en) begin
      regs[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state == MEM && mem_last && mem_rw_q) dmem[mem_idx] <= b_q;
  end
endmodule

// File: tb/tb_datapath_mc.sv
// Directed-vector bench for datapath_mc with three memory wait states.
module tb_datapath_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [2:0]  ImmSel;
  logic        RegWEn, Bsel, MemRW, WBSel;
  logic [3:0]  ALUSel;
  logic        done, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  datapath_mc #(.XLEN(32), .NREGS(32), .DMEM_DEPTH(256), .MEM_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .ImmSel(ImmSel), .RegWEn(RegWEn), .Bsel(Bsel), .ALUSel(ALUSel),
    .MemRW(MemRW), .WBSel(WBSel), .done(done), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, obs);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    dbg_addr = r;
    #1;
    check(tag, dbg_data, exp);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  // Issue one instruction, then scramble every input so only latched values can matter.
  task automatic run_instr(input string tag, input logic [31:0] i, input logic [2:0] isel,
                           input logic rwe, input logic bs, input logic [3:0] asel,
                           input logic mrw, input logic wbs, input int lat,
                           input logic exp_en, input logic [31:0] exp_data);
    int  cyc;
    bit  seen;
    check({tag, "_ready"}, 32'(inst_ready), 32'd1);
    inst = i; ImmSel = isel; RegWEn = rwe; Bsel = bs; ALUSel = asel; MemRW = mrw; WBSel = wbs;
    inst_valid = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      inst_valid = 1'b0;
      inst = ~i; ImmSel = ~isel; RegWEn = ~rwe; Bsel = ~bs; ALUSel = ~asel; MemRW = 1'b0; WBSel = ~wbs;
      if (done) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_wb_en"}, 32'(wb_en), 32'(exp_en));
    check({tag, "_wb_addr"}, 32'(wb_addr), 32'(i[11:7]));
    check({tag, "_wb_data"}, wb_data, exp_data);
    @(posedge clk); #1;
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_hold"}, wb_data, exp_data);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; inst_valid = 1'b0; inst = '0; ImmSel = '0; RegWEn = 1'b0; Bsel = 1'b0;
    ALUSel = '0; MemRW = 1'b0; WBSel = 1'b0; dbg_addr = '0;
    @(posedge clk); #1;
    check("rst_ready", 32'(inst_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check_reg("rst_x1", 5'd1, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU-only ops: done three cycles after acceptance
    run_instr("addi_x1", enc_i(12'd5, 5'd0, 5'd1), 3'b000, 1, 1, 4'd0, 0, 1, 3, 1, 32'd5);
    check_reg("x1", 5'd1, 32'd5);
    run_instr("addi_x2", enc_i(12'd7, 5'd0, 5'd2), 3'b000, 1, 1, 4'd0, 0, 1, 3, 1, 32'd7);
    run_instr("sub_x3", enc_r(7'h20, 5'd2, 5'd1, 5'd3), 3'b000, 1, 0, 4'd1, 0, 1, 3, 1, 32'hFFFF_FFFE);
    check_reg("x3", 5'd3, 32'hFFFF_FFFE);
    // srai encoding carries funct7 in imm[11:5]; only the low five bits shift
    run_instr("srai_x4", enc_i(12'h401, 5'd3, 5'd4), 3'b000, 1, 1, 4'd7, 0, 1, 3, 1, 32'hFFFF_FFFF);
    check_reg("x4", 5'd4, 32'hFFFF_FFFF);

    // Memory ops: 4 + MEM_LAT cycles
    run_instr("sw_x1", enc_s(12'd8, 5'd1, 5'd0), 3'b001, 0, 1, 4'd0, 1, 1, 7, 0, 32'd8);
    run_instr("lw_x5", enc_i(12'd8, 5'd0, 5'd5), 3'b000, 1, 1, 4'd0, 0, 0, 7, 1, 32'd5);
    check_reg("x5", 5'd5, 32'd5);
    run_instr("lw_alias_x9", enc_i(12'd1032, 5'd0, 5'd9), 3'b000, 1, 1, 4'd0, 0, 0, 7, 1, 32'd5);
    check_reg("x9", 5'd9, 32'd5);
    // Store whose rd field (imm[4:0]=8) gets the pre-store word
    run_instr("sw_rd_x8", enc_s(12'd8, 5'd2, 5'd0), 3'b001, 1, 1, 4'd0, 1, 0, 7, 1, 32'd5);
    check_reg("x8", 5'd8, 32'd5);
    run_instr("lw_x10", enc_i(12'd8, 5'd0, 5'd10), 3'b000, 1, 1, 4'd0, 0, 0, 7, 1, 32'd7);
    check_reg("x10", 5'd10, 32'd7);

    run_instr("addi_x0", enc_i(12'd9, 5'd0, 5'd0), 3'b000, 1, 1, 4'd0, 0, 1, 3, 0, 32'd9);
    check_reg("x0", 5'd0, 32'd0);
    run_instr("addi_x6", enc_i(12'd3, 5'd0, 5'd6), 3'b000, 1, 1, 4'd0, 0, 1, 3, 1, 32'd3);
    run_instr("badsel_x6", enc_i(12'h7FF, 5'd0, 5'd6), 3'b111, 1, 1, 4'd0, 0, 1, 3, 1, 32'd0);
    check_reg("x6", 5'd6, 32'd0);

    // inst_valid held for 8 edges: exactly two passes of x11 += 1
    inst = enc_i(12'd1, 5'd11, 5'd11); ImmSel = 3'b000; RegWEn = 1'b1; Bsel = 1'b1;
    ALUSel = 4'd0; MemRW = 1'b0; WBSel = 1'b1; inst_valid = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    inst_valid = 1'b0;
    check("hold_dones", 32'(dones), 32'd2);
    check_reg("hold_x11", 5'd11, 32'd2);

    // Reset asserted while ADDI x7 sits in EXEC
    inst = enc_i(12'd13, 5'd0, 5'd7); ImmSel = 3'b000; RegWEn = 1'b1; Bsel = 1'b1;
    ALUSel = 4'd0; MemRW = 1'b0; WBSel = 1'b1; inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(inst_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_dones", 32'(dones), 32'd0);
    check_reg("abort_x7", 5'd7, 32'd0);
    check_reg("abort_x1", 5'd1, 32'd0);
    check_reg("abort_x5", 5'd5, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
